// File: rtl/axi_ram_responder_if.sv
// AXI3-style bus bundle for the RAM responder: AR/R/AW/W/B channels.
// The slave modport is the responder's view and the master modport is the initiator's view.
interface axi_ram_responder_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_ram_responder.sv
// Word-addressed AXI RAM responder with independent read and write FSMs.
// FIXED, INCR and WRAP bursts are supported; accesses outside the window answer DECERR.
module axi_ram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1FC0_0000,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input logic             aclk,
  input logic             aresetn,
  axi_ram_responder_if.slave bus
);
  localparam int unsigned IW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [1:0]  OKAY     = 2'b00;
  localparam logic [1:0]  DECERR   = 2'b11;

  typedef enum logic       {R_IDLE, R_BURST}         r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_e;

  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    return IW'((a - BASE_ADDR) >> 2);
  endfunction

  // Beat size is always 4 bytes; WRAP stays inside an aligned (len+1)*4-byte window.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [3:0] len,
                                            input logic [1:0] burst);
    logic [31:0] wrap_mask;
    wrap_mask = (({28'd0, len} + 32'd1) << 2) - 32'd1;
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~wrap_mask) | ((a + 32'd4) & wrap_mask);
      default: return a + 32'd4;
    endcase
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  // ---------------- read channel ----------------
  r_state_e    r_state_q, r_state_d;
  logic [3:0]  rid_q, rlen_q, rbeat_q;
  logic [1:0]  rburst_q, rresp_q;
  logic [31:0] raddr_q, rdata_q, rd_addr;
  logic        rlast_q, rd_load, ar_hs, r_hs;

  assign bus.arready = (r_state_q == R_IDLE);
  assign bus.rvalid  = (r_state_q == R_BURST);
  assign bus.rid     = rid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rlast_q;
  assign ar_hs       = bus.arready && bus.arvalid;
  assign r_hs        = bus.rvalid && bus.rready;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    r_state_d = r_state_q;
    rd_load   = 1'b0;
    rd_addr   = raddr_q;
    case (r_state_q)
      R_IDLE: if (bus.arvalid) begin
        r_state_d = R_BURST;
        rd_load   = 1'b1;
        rd_addr   = {bus.araddr[31:2], 2'b00};
      end
      R_BURST: if (bus.rready) begin
        if (rlast_q) begin
          r_state_d = R_IDLE;
        end else begin
          rd_load = 1'b1;
          rd_addr = next_addr(raddr_q, rlen_q, rburst_q);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rburst_q  <= '0;
      rresp_q   <= OKAY;
      raddr_q   <= '0;
      rdata_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        rid_q    <= bus.arid;
        rlen_q   <= bus.arlen;
        rburst_q <= bus.arburst;
        rbeat_q  <= '0;
        rlast_q  <= (bus.arlen == 4'd0);
      end else if (rd_load) begin
        rbeat_q  <= rbeat_q + 4'd1;
        rlast_q  <= (rbeat_q + 4'd1 == rlen_q);
      end else if (r_hs) begin
        rlast_q  <= 1'b0;
      end
      // Synchronous read: a same-cycle write to this word lands after the fetch.
      if (rd_load) begin
        raddr_q <= rd_addr;
        rdata_q <= in_range(rd_addr) ? mem[word_idx(rd_addr)] : '0;
        rresp_q <= in_range(rd_addr) ? OKAY : DECERR;
      end
    end
  end

  // ---------------- write channel ----------------
  w_state_e    w_state_q, w_state_d;
  logic [3:0]  bid_q, wlen_q, wbeat_q;
  logic [1:0]  wburst_q, bresp_q;
  logic [31:0] waddr_q;
  logic        wover_q, werr_q, aw_hs, w_hs, beat_err, mem_we;

  assign bus.awready = (w_state_q == W_IDLE);
  assign bus.wready  = (w_state_q == W_DATA);
  assign bus.bvalid  = (w_state_q == W_RESP);
  assign bus.bid     = bid_q;
  assign bus.bresp   = bresp_q;
  assign aw_hs       = bus.awready && bus.awvalid;
  assign w_hs        = bus.wready && bus.wvalid;
  // Beats past awlen+1 are swallowed: they neither write nor flag errors.
  assign beat_err    = !wover_q && !in_range(waddr_q);
  assign mem_we      = w_hs && !wover_q && in_range(waddr_q);

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (bus.awvalid)               w_state_d = W_DATA;
      W_DATA:  if (bus.wvalid && bus.wlast)   w_state_d = W_RESP;
      W_RESP:  if (bus.bready)                w_state_d = W_IDLE;
      default:                                w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      bid_q     <= '0;
      wlen_q    <= '0;
      wbeat_q   <= '0;
      wburst_q  <= '0;
      bresp_q   <= OKAY;
      waddr_q   <= '0;
      wover_q   <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        bid_q    <= bus.awid;
        wlen_q   <= bus.awlen;
        wburst_q <= bus.awburst;
        waddr_q  <= {bus.awaddr[31:2], 2'b00};
        wbeat_q  <= '0;
        wover_q  <= 1'b0;
        werr_q   <= 1'b0;
      end else if (w_hs) begin
        waddr_q <= next_addr(waddr_q, wlen_q, wburst_q);
        wbeat_q <= wbeat_q + 4'd1;
        if (wbeat_q == wlen_q) wover_q <= 1'b1;
        werr_q  <= werr_q | beat_err;
        if (bus.wlast) bresp_q <= (werr_q | beat_err) ? DECERR : OKAY;
      end
    end
  end

  // NOTE: the storage array has no reset; contents survive aresetn and map onto plain RAM.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem[word_idx(waddr_q)][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{bus.arsize, bus.arlock, bus.arcache, bus.arprot, bus.araddr[1:0],
                           bus.awsize, bus.awlock, bus.awcache, bus.awprot, bus.awaddr[1:0],
                           bus.wid};
endmodule
